bldc_hbridge_deadtime: RTL and testbench
========================================

# bldc_hbridge_deadtime

- Sits directly downstream of the BLDC ESC speed/PID stage in the motor output path.
- Takes the ESC's `motor_positive` / `motor_negative` PWM drive requests and turns them into four H-bridge gate signals.
- Guarantees programmable dead time on every change of drive state, blocks shoot-through request pairs, and latches an external over-current fault until software clears it.
- Gate outputs are registered and go straight to the pads.

## Interface
Parameters:
- `DT_WIDTH`, 8 — width of the dead-time count.
- `CNT_WIDTH`, 8 — width of the saturating conflict counter.

Ports:
- `clk`  in  1 — system clock. One clock only.
- `reset_n`  in  1 — asynchronous, active-low reset.
- `en`  in  1 — bridge enable. Low is treated as an OFF request.
- `pos_req`  in  1 — forward drive request (ESC `motor_positive`).
- `neg_req`  in  1 — reverse drive request (ESC `motor_negative`).
- `dead_time`  in  DT_WIDTH — dead-time length in clk cycles. Sampled when DEAD is entered.
- `fault_in`  in  1 — asynchronous over-current flag, active high.
- `fault_clear`  in  1 — synchronous clear pulse for a latched fault.
- `gate_ah`, `gate_al`, `gate_bh`, `gate_bl`  out  1 each — bridge gates. Forward = `ah`+`bl`; reverse = `bh`+`al`.
- `fault`  out  1 — high while in FAULT.
- `conflict_cnt`  out  CNT_WIDTH — saturating count of cycles with `pos_req & neg_req`.

## Operation
Request decode, each cycle:
- FWD when `en & pos_req & ~neg_req`.
- REV when `en & neg_req & ~pos_req`.
- OFF otherwise.
- Both requests high is treated as OFF and increments `conflict_cnt`. The counter saturates at all-ones and clears only on reset.

States:
- IDLE — all gates low. Goes to FWD or REV on the matching request; stays on OFF.
- FWD — `gate_ah` = `gate_bl` = 1. Any request other than FWD moves to DEAD.
- REV — `gate_bh` = `gate_al` = 1. Any request other than REV moves to DEAD.
- DEAD — all gates low.
  - On entry, loads `dt_cnt` = max(`dead_time`, 1). A `dead_time` of 0 still gives one dead cycle.
  - Decrements each cycle.
  - On the edge where `dt_cnt` == 1, exits to FWD, REV or IDLE according to the request decoded on that edge.
  - A request change during DEAD does not restart the count.
- FAULT — all gates low, `fault` = 1.
  - Entered from any state when the synchronized fault is high; this takes priority over all other transitions.
  - Left only when `fault_clear` = 1 and the synchronized fault = 0 on the same edge. Exit goes to DEAD, so a full dead time runs before any re-drive.
  - `fault_clear` while the fault is still high is ignored.

Invariants:
- `gate_ah & gate_al` = 0 and `gate_bh & gate_bl` = 0 on every cycle.
- FWD ↔ REV never happens without an intervening DEAD.

Reset (asynchronous):
- State = IDLE.
- All gates = 0, `fault` = 0, `conflict_cnt` = 0, `dt_cnt` = 0.
- Both synchronizer flops = 0.

## Timing
- All outputs are registered from the state register; there are no combinational paths from input to output.
- IDLE → drive: request sampled at edge k → gates high after edge k (latency 1 cycle from request setup).
- Drive → change: new request at edge k → all gates low after edge k. Gates for the new target assert after edge k + D, with D = max(`dead_time`, 1). The bridge is all-off for exactly D cycles.
- Fault path:
  - `fault_in` passes through a 2-flop synchronizer.
  - `fault_in` high before edge k → synchronized high after edge k+1 → gates low and `fault` = 1 after edge k+2.
  - Fault pulses shorter than one clock period may be missed.
- Fault exit: `fault_clear` accepted at edge k → DEAD after edge k → earliest re-drive after edge k + D.
- Simultaneous events, by priority:
  1. Fault beats everything.
  2. DEAD expiry beats a request change on the same edge; the target is the request decoded at that edge.
  3. An `en` drop in FWD/REV is handled like an OFF request, i.e. goes to DEAD.
- Reset asserted mid-DEAD or mid-FAULT: immediate asynchronous return to IDLE; the latched fault is lost.
- Upstream requests change at most once per 8 clocks. The block must not rely on this.

## Structure
- Shared package `bldc_pkg`:
  - state typedef `bridge_state_t` (IDLE, FWD, REV, DEAD, FAULT);
  - gate-pattern constants `GATES_OFF`, `GATES_FWD`, `GATES_REV` as 4-bit {ah, al, bh, bl};
  - request decode typedef `drive_req_t` (OFF, FWD, REV).
- One sub-module: `sync_2ff`, a 2-flop synchronizer with async active-low reset, used for `fault_in`.

## Test plan
- Reset, then `en`=1, `pos_req`=1 → `gate_ah`=`gate_bl`=1 one cycle later; all other gates 0.
- `dead_time`=5, switch request FWD → REV → all gates 0 for exactly 5 cycles, then `gate_bh`=`gate_al`=1.
- `dead_time`=0, FWD → OFF → exactly 1 all-off DEAD cycle, then IDLE.
- `pos_req`=`neg_req`=1 for 300 cycles while in IDLE:
  - gates stay 0;
  - `conflict_cnt` saturates at 255.
- `fault_in` pulse during FWD:
  - gates low and `fault`=1 two edges after sampling;
  - `fault_clear` while `fault_in` is high is ignored;
  - a later `fault_clear` gives DEAD for `dead_time` cycles, then FWD resumes.
- Reset asserted asynchronously mid-DEAD (`dead_time`=200):
  - all outputs 0 immediately, with no clock edge;
  - `conflict_cnt`=0.
- Every test: a continuous assertion checks that no high/low pair on the same leg is ever 1 together.

Source files
------------

// File: rtl/bldc_pkg.sv
// Shared types and constants for the BLDC H-bridge dead-time block.
// - bridge_state_t : controller state (idle, forward, reverse, dead, fault)
// - drive_req_t    : per-cycle decoded drive request
// - GATES_*        : gate patterns packed as {ah, al, bh, bl}
package bldc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FWD   = 3'd1,
    ST_REV   = 3'd2,
    ST_DEAD  = 3'd3,
    ST_FAULT = 3'd4
  } bridge_state_t;

  typedef enum logic [1:0] {
    REQ_OFF = 2'd0,
    REQ_FWD = 2'd1,
    REQ_REV = 2'd2
  } drive_req_t;

  localparam logic [3:0] GATES_OFF = 4'b0000;
  localparam logic [3:0] GATES_FWD = 4'b1001;  // ah + bl
  localparam logic [3:0] GATES_REV = 4'b0110;  // al + bh

  // Both requests high, or bridge disabled, decodes as OFF.
  function automatic drive_req_t decode_req(input logic en, input logic pos, input logic neg);
    if (en && pos && !neg) return REQ_FWD;
    if (en && neg && !pos) return REQ_REV;
    return REQ_OFF;
  endfunction

  function automatic bridge_state_t req_to_state(input drive_req_t req);
    case (req)
      REQ_FWD: return ST_FWD;
      REQ_REV: return ST_REV;
      default: return ST_IDLE;
    endcase
  endfunction

  function automatic logic [3:0] gates_for(input bridge_state_t st);
    case (st)
      ST_FWD:  return GATES_FWD;
      ST_REV:  return GATES_REV;
      default: return GATES_OFF;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports: i_clk (clock), i_rst_n (async active-low reset),
//        i_d (async input), o_q (synchronized output, 2-cycle latency).
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/bldc_hbridge_deadtime.sv
// H-bridge gate controller with programmable dead time, shoot-through
// request blocking and a latched over-current fault.
// Ports:
//   clk, reset_n          : clock, async active-low reset
//   en, pos_req, neg_req  : bridge enable and ESC drive requests
//   dead_time             : dead-time length in cycles (sampled on DEAD entry)
//   fault_in, fault_clear : async over-current flag, sync clear pulse
//   gate_ah/al/bh/bl      : registered gate outputs
//   fault                 : high while faulted
//   conflict_cnt          : saturating count of pos_req & neg_req cycles
module bldc_hbridge_deadtime
  import bldc_pkg::*;
#(
  parameter int unsigned DT_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 pos_req,
  input  logic                 neg_req,
  input  logic [DT_WIDTH-1:0]  dead_time,
  input  logic                 fault_in,
  input  logic                 fault_clear,
  output logic                 gate_ah,
  output logic                 gate_al,
  output logic                 gate_bh,
  output logic                 gate_bl,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] conflict_cnt
);

  localparam logic [DT_WIDTH-1:0]  DT_ONE  = DT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  bridge_state_t        r_state;
  bridge_state_t        w_next;
  drive_req_t           w_req;
  logic                 w_load_dt;
  logic                 w_fault_s;
  logic [DT_WIDTH-1:0]  w_dt_init;
  logic [DT_WIDTH-1:0]  r_dt_cnt;
  logic [3:0]           r_gates;
  logic                 r_fault;
  logic [CNT_WIDTH-1:0] r_conflict_cnt;

  sync_2ff u_fault_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (fault_in),
    .o_q     (w_fault_s)
  );

  // A zero dead time still yields one all-off cycle.
  assign w_dt_init = (dead_time == '0) ? DT_ONE : dead_time;

  always_comb begin
    w_req     = decode_req(en, pos_req, neg_req);
    w_next    = r_state;
    w_load_dt = 1'b0;
    if (w_fault_s) begin
      w_next = ST_FAULT;
    end else begin
      case (r_state)
        ST_IDLE: w_next = req_to_state(w_req);
        ST_FWD: begin
          if (w_req != REQ_FWD) begin
            w_next    = ST_DEAD;
            w_load_dt = 1'b1;
          end
        end
        ST_REV: begin
          if (w_req != REQ_REV) begin
            w_next    = ST_DEAD;
            w_load_dt = 1'b1;
          end
        end
        // Expiry target is whatever is requested on the expiring edge;
        // request changes mid-count never reload the counter.
        ST_DEAD: begin
          if (r_dt_cnt <= DT_ONE) w_next = req_to_state(w_req);
        end
        ST_FAULT: begin
          if (fault_clear) begin
            w_next    = ST_DEAD;
            w_load_dt = 1'b1;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // Gates and fault flag are registered from the next-state decode so they
  // change on the same edge as the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_gates  <= GATES_OFF;
      r_fault  <= 1'b0;
      r_dt_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_gates <= gates_for(w_next);
      r_fault <= (w_next == ST_FAULT);
      if (w_load_dt) begin
        r_dt_cnt <= w_dt_init;
      end else if (r_state == ST_DEAD && r_dt_cnt != '0) begin
        r_dt_cnt <= r_dt_cnt - DT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_conflict_cnt <= '0;
    end else if (pos_req && neg_req && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + CNT_ONE;
    end
  end

  assign gate_ah      = r_gates[3];
  assign gate_al      = r_gates[2];
  assign gate_bh      = r_gates[1];
  assign gate_bl      = r_gates[0];
  assign fault        = r_fault;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_bldc_hbridge_deadtime.sv
module tb_bldc_hbridge_deadtime;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       pos_req = 1'b0;
  logic       neg_req = 1'b0;
  logic [7:0] dead_time = 8'd0;
  logic       fault_in = 1'b0;
  logic       fault_clear = 1'b0;
  logic       gate_ah, gate_al, gate_bh, gate_bl, fault;
  logic [7:0] conflict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bldc_hbridge_deadtime #(.DT_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .pos_req      (pos_req),
    .neg_req      (neg_req),
    .dead_time    (dead_time),
    .fault_in     (fault_in),
    .fault_clear  (fault_clear),
    .gate_ah      (gate_ah),
    .gate_al      (gate_al),
    .gate_bh      (gate_bh),
    .gate_bl      (gate_bl),
    .fault        (fault),
    .conflict_cnt (conflict_cnt)
  );

  wire [3:0] gates = {gate_ah, gate_al, gate_bh, gate_bl};

  // ---------------- reference model ----------------
  // m_drive: 0 none, 1 forward, 2 reverse. m_off_left > 0 means the bridge
  // is in a forced all-off window with that many edges left.
  int       m_drive;
  int       m_off_left;
  bit       m_fault;
  bit [1:0] m_fhist;
  int       m_cnt;

  task automatic model_reset();
    m_drive = 0; m_off_left = 0; m_fault = 0; m_fhist = 2'b00; m_cnt = 0;
  endtask

  task automatic model_step();
    bit f;
    int want;
    int dwin;
    f = m_fhist[1];
    want = !en ? 0 : (pos_req && !neg_req) ? 1 : (neg_req && !pos_req) ? 2 : 0;
    dwin = (dead_time == 0) ? 1 : int'(dead_time);
    if (pos_req && neg_req && m_cnt < 255) m_cnt++;
    m_fhist = {m_fhist[0], fault_in};
    if (f) begin
      m_fault = 1; m_drive = 0; m_off_left = 0;
    end else if (m_fault) begin
      if (fault_clear) begin m_fault = 0; m_off_left = dwin; end
    end else if (m_off_left > 0) begin
      if (m_off_left == 1) begin m_off_left = 0; m_drive = want; end
      else m_off_left--;
    end else if (m_drive == 0) begin
      m_drive = want;
    end else if (want != m_drive) begin
      m_drive = 0; m_off_left = dwin;
    end
  endtask

  function automatic logic [3:0] model_gates();
    if (m_drive == 1) return 4'b1001;
    if (m_drive == 2) return 4'b0110;
    return 4'b0000;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic set_in(input logic e, input logic p, input logic n, input logic [7:0] dt);
    en = e; pos_req = p; neg_req = n; dead_time = dt;
  endtask

  // Shoot-through invariant on every cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      n_checks++;
      if ((gate_ah && gate_al) || (gate_bh && gate_bl)) begin
        n_fail++;
        $display("FAIL leg_overlap: gates=%b required no leg pair high at %0t", gates, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic       e, p, n;
    logic [7:0] dt;
    logic [3:0] g;
  } vec_t;

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'd5, 4'b1001};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'd5, 4'b1001};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'd5, 4'b0000};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'd5, 4'b0000};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'd5, 4'b0000};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'd5, 4'b0000};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'd5, 4'b0000};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 8'd5, 4'b0110};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'd5, 4'b0110};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'd0, 4'b0000};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 8'd0, 4'b0000};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 8'd0, 4'b0000};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 8'd0, 4'b1001};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 8'd0, 4'b0000};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 8'd0, 4'b1001};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 8'd0, 4'b0000};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 8'd0, 4'b0110};

    // Reset state
    model_reset();
    #3;
    check("reset_gates", {28'd0, gates}, 32'd0);
    check("reset_fault", {31'd0, fault}, 32'd0);
    check("reset_cnt", {24'd0, conflict_cnt}, 32'd0);
    do_reset();

    // Table: FWD, FWD->REV with 5 dead cycles, OFF with dead_time 0, etc.
    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].e, tbl[i].p, tbl[i].n, tbl[i].dt);
      tick();
      check($sformatf("table[%0d]", i), {28'd0, gates}, {28'd0, tbl[i].g});
    end
    check("table_cnt", {24'd0, conflict_cnt}, 32'd1);

    // Conflict saturation in IDLE
    set_in(1'b0, 1'b0, 1'b0, 8'd0);
    do_reset();
    set_in(1'b1, 1'b1, 1'b1, 8'd0);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (gates !== 4'b0000) check("conflict_gates", {28'd0, gates}, 32'd0);
      if (i == 99) check("conflict_cnt_100", {24'd0, conflict_cnt}, 32'd100);
    end
    check("conflict_gates_end", {28'd0, gates}, 32'd0);
    check("conflict_cnt_sat", {24'd0, conflict_cnt}, 32'd255);

    // Fault during FWD, ignored clear, then clean clear
    set_in(1'b0, 1'b0, 1'b0, 8'd3);
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 8'd3);
    tick(); check("flt_pre_fwd", {28'd0, gates}, 32'h9);
    fault_in = 1'b1;
    tick(); check("flt_k_gates", {27'd0, fault, gates}, 32'h09);
    tick(); check("flt_k1_gates", {27'd0, fault, gates}, 32'h09);
    tick(); check("flt_k2_gates", {27'd0, fault, gates}, 32'h10);
    fault_clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check("flt_clear_ignored", {27'd0, fault, gates}, 32'h10);
    end
    fault_clear = 1'b0;
    fault_in = 1'b0;
    tick(); check("flt_sync_j", {31'd0, fault}, 32'd1);
    tick(); check("flt_sync_j1", {31'd0, fault}, 32'd1);
    fault_clear = 1'b1;
    tick(); check("flt_exit", {27'd0, fault, gates}, 32'h00);
    fault_clear = 1'b0;
    tick(); check("flt_dead1", {28'd0, gates}, 32'd0);
    tick(); check("flt_dead2", {28'd0, gates}, 32'd0);
    tick(); check("flt_refwd", {27'd0, fault, gates}, 32'h09);

    // Async reset mid-DEAD
    set_in(1'b0, 1'b0, 1'b0, 8'd200);
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 8'd200);
    tick(); tick();
    check("rst_pre_fwd", {28'd0, gates}, 32'h9);
    neg_req = 1'b1;
    tick();
    check("rst_dead_gates", {28'd0, gates}, 32'd0);
    check("rst_pre_cnt", {24'd0, conflict_cnt}, 32'd1);
    neg_req = 1'b0;
    repeat (10) tick();
    check("rst_still_dead", {28'd0, gates}, 32'd0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_out", {23'd0, fault, gates, conflict_cnt}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Randomized run against the model
    begin
      int hold;
      int fpulse;
      hold = 0; fpulse = 0;
      set_in(1'b1, 1'b0, 1'b0, 8'd2);
      fault_in = 1'b0; fault_clear = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if (hold == 0) begin
          int r;
          r = $urandom_range(0, 9);
          en = (r != 0);
          pos_req = (r >= 1 && r <= 4) || r == 9;
          neg_req = (r >= 5 && r <= 8) || r == 9;
          if ($urandom_range(0, 3) == 0) dead_time = 8'($urandom_range(0, 6));
          hold = $urandom_range(1, 12);
        end else begin
          hold--;
        end
        if (fpulse > 0) begin
          fpulse--;
          fault_in = (fpulse != 0);
        end else if ($urandom_range(0, 149) == 0) begin
          fpulse = $urandom_range(1, 5);
          fault_in = 1'b1;
        end
        fault_clear = ($urandom_range(0, 7) == 0);
        tick();
        check($sformatf("rand[%0d]", i), {19'd0, fault, gates, conflict_cnt},
              {19'd0, m_fault, model_gates(), 8'(m_cnt)});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
